// File: rtl/mpd_rx_hdr_extract.sv
// MPD receive front-end: claims a PRT slot, streams a frame into it and extracts the IPv4 5-tuple.
// Descriptor visible two cycles after the last byte; rx_ready follows prt_ready while streaming, a new frame waits for descriptor space.
module mpd_rx_hdr_extract #(
  parameter int FRAME_SIZE = 1500,
  parameter int SLOT_W     = 4,
  parameter int DESC_DEPTH = 4,
  parameter int VLAN_EN    = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slot_avail,
  input  logic [SLOT_W-1:0] slot_id,
  output logic              slot_take,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_last,
  output logic              rx_ready,
  input  logic              prt_ready,
  output logic              prt_wr_valid,
  output logic [7:0]        prt_wr_data,
  output logic              prt_wr_last,
  output logic [SLOT_W-1:0] prt_wr_slot,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [103:0]      hdr_data,
  output logic [SLOT_W-1:0] hdr_slot,
  output logic [3:0]        hdr_flags,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_errors
);

  localparam int IW_RAW = $clog2(FRAME_SIZE + 1);
  localparam int IW     = (IW_RAW > 6) ? IW_RAW : 6;
  localparam int AW     = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;

  typedef struct packed {
    logic [15:0] dstpt;
    logic [15:0] srcpt;
    logic [31:0] dstip;
    logic [31:0] srcip;
    logic [7:0]  proto;
  } hdr_t;

  typedef struct packed {
    hdr_t              hdr;
    logic [SLOT_W-1:0] slot;
    logic [3:0]        flags;
  } desc_t;

  typedef enum logic [2:0] {S_IDLE, S_CLAIM, S_STREAM, S_DISCARD, S_COMMIT} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [SLOT_W-1:0] r_slot;
  hdr_t              r_hdr;
  logic              r_f_ovs, r_f_short, r_f_nonip, r_f_vlan;
  logic [7:0]        r_prev;
  logic              r_slot_take;
  logic [CNT_W-1:0]  r_frames, r_errors;

  desc_t             r_mem [DESC_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_cnt;

  logic          w_stream, w_acc, w_cap_end, w_vlan_hit, w_etype_chk, w_nonip_hit, w_short_hit;
  logic          w_space, w_push, w_pop;
  logic [IW-1:0] w_rel;
  desc_t         w_desc, w_head;

  assign w_stream  = (r_state == S_STREAM);
  assign w_acc     = rx_valid & rx_ready;
  assign w_cap_end = (r_idx == IW'(FRAME_SIZE - 1));
  // Field offsets are relative to the end of the optional tag; the tag is known from idx 14 on.
  assign w_rel       = r_idx - (r_f_vlan ? IW'(4) : IW'(0));
  assign w_vlan_hit  = (VLAN_EN != 0) && (r_idx == IW'(13)) && (r_prev == 8'h81) && (rx_data == 8'h00);
  assign w_etype_chk = ((r_idx == IW'(13)) && !w_vlan_hit) || ((r_idx == IW'(17)) && r_f_vlan);
  assign w_nonip_hit = w_etype_chk && ({r_prev, rx_data} != 16'h0800);
  assign w_short_hit = r_idx < (r_f_vlan ? IW'(41) : IW'(37));

  assign rx_ready     = w_stream ? prt_ready : (r_state == S_DISCARD);
  assign prt_wr_valid = w_stream & rx_valid & prt_ready;
  assign prt_wr_data  = w_stream ? rx_data : 8'h00;
  assign prt_wr_last  = w_stream & rx_valid & (rx_last | w_cap_end);
  assign prt_wr_slot  = r_slot;
  assign slot_take    = r_slot_take;
  assign stat_frames  = r_frames;
  assign stat_errors  = r_errors;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_slot      <= '0;
      r_hdr       <= '0;
      r_f_ovs     <= 1'b0;
      r_f_short   <= 1'b0;
      r_f_nonip   <= 1'b0;
      r_f_vlan    <= 1'b0;
      r_prev      <= 8'h00;
      r_slot_take <= 1'b0;
      r_frames    <= '0;
      r_errors    <= '0;
    end else begin
      r_slot_take <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (slot_avail && rx_valid && w_space) begin
            r_state     <= S_CLAIM;
            r_slot_take <= 1'b1;
          end
        end
        S_CLAIM: begin
          r_slot    <= slot_id;
          r_idx     <= '0;
          r_hdr     <= '0;
          r_f_ovs   <= 1'b0;
          r_f_short <= 1'b0;
          r_f_nonip <= 1'b0;
          r_f_vlan  <= 1'b0;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_acc) begin
            r_idx  <= r_idx + IW'(1);
            r_prev <= rx_data;
            if (w_vlan_hit)  r_f_vlan  <= 1'b1;
            if (w_nonip_hit) r_f_nonip <= 1'b1;
            case (w_rel)
              IW'(23): r_hdr.proto         <= rx_data;
              IW'(26): r_hdr.srcip[31:24]  <= rx_data;
              IW'(27): r_hdr.srcip[23:16]  <= rx_data;
              IW'(28): r_hdr.srcip[15:8]   <= rx_data;
              IW'(29): r_hdr.srcip[7:0]    <= rx_data;
              IW'(30): r_hdr.dstip[31:24]  <= rx_data;
              IW'(31): r_hdr.dstip[23:16]  <= rx_data;
              IW'(32): r_hdr.dstip[15:8]   <= rx_data;
              IW'(33): r_hdr.dstip[7:0]    <= rx_data;
              IW'(34): r_hdr.srcpt[15:8]   <= rx_data;
              IW'(35): r_hdr.srcpt[7:0]    <= rx_data;
              IW'(36): r_hdr.dstpt[15:8]   <= rx_data;
              IW'(37): r_hdr.dstpt[7:0]    <= rx_data;
              default: ;
            endcase
            if (rx_last) begin
              r_f_short <= w_short_hit;
              r_state   <= S_COMMIT;
            end else if (w_cap_end) begin
              r_f_ovs <= 1'b1;
              r_state <= S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (w_acc && rx_last) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_frames != '1) r_frames <= r_frames + CNT_W'(1);
          if ((r_f_ovs || r_f_short) && (r_errors != '1)) r_errors <= r_errors + CNT_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Descriptor FIFO, first-word-fall-through; head is zeroed when empty.
  assign w_desc  = '{hdr: r_hdr, slot: r_slot, flags: {r_f_ovs, r_f_short, r_f_nonip, r_f_vlan}};
  assign w_push  = (r_state == S_COMMIT);
  assign w_pop   = hdr_ready && (r_cnt != '0);
  assign w_space = (r_cnt < (AW+1)'(DESC_DEPTH));
  assign w_head  = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;

  assign hdr_valid = (r_cnt != '0);
  assign hdr_data  = w_head.hdr;
  assign hdr_slot  = w_head.slot;
  assign hdr_flags = w_head.flags;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_desc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule
